// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and the IF/ID payload type.
// Field geometry, opcodes and the default bubble word all live here.
package mips_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned OPCODE_W   = 6;
  localparam int unsigned REG_W      = 5;
  localparam int unsigned SHAMT_W    = 5;
  localparam int unsigned FUNCT_W    = 6;
  localparam int unsigned IMM_W      = 16;
  localparam int unsigned TARGET_W   = 26;

  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned RS_LSB     = 21;
  localparam int unsigned RT_LSB     = 16;
  localparam int unsigned RD_LSB     = 11;
  localparam int unsigned SHAMT_LSB  = 6;
  localparam int unsigned FUNCT_LSB  = 0;
  localparam int unsigned IMM_LSB    = 0;
  localparam int unsigned TARGET_LSB = 0;

  localparam logic [XLEN-1:0] DEFAULT_NOP_INSTR = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP           = 32'h0000_0004;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'h02;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPCODE_W-1:0] OP_LUI   = 6'h0F;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;

  // Word carried from fetch to decode: 64 bits, pc in the upper half.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } if_id_payload_t;

  // Payload shown on the outputs while no word is valid.
  function automatic if_id_payload_t bubble(input logic [XLEN-1:0] nop);
    if_id_payload_t p;
    p.pc    = '0;
    p.instr = nop;
    return p;
  endfunction

endpackage

// File: rtl/if_id_skid.sv
// Valid/ready holding register between fetch and decode.
// Defining IF_ID_SKID_EN adds a one-entry skid slot and a registered in_ready.
module if_id_skid
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  logic           in_valid,
  output logic           in_ready,
  input  if_id_payload_t in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output if_id_payload_t out_data
);

  localparam if_id_payload_t IDLE = bubble(NOP_INSTR);

  if_id_payload_t main_q, main_d;
  logic           main_v_q, main_v_d;
  logic           accept;
  logic           retire;

  assign retire    = main_v_q && out_ready;
  assign out_valid = main_v_q;
  assign out_data  = main_q;

`ifdef IF_ID_SKID_EN
  if_id_payload_t skid_q, skid_d;
  logic           skid_v_q, skid_v_d;
  logic           in_ready_q;

  assign in_ready = in_ready_q;
  assign accept   = in_valid && in_ready_q;

  // Skid slot drains into main before anything new is taken.
  always_comb begin
    main_v_d = main_v_q;
    main_d   = main_q;
    skid_v_d = skid_v_q;
    skid_d   = skid_q;
    if (flush) begin
      main_v_d = 1'b0;
      main_d   = IDLE;
      skid_v_d = 1'b0;
      skid_d   = IDLE;
    end else if (skid_v_q) begin
      if (retire) begin
        main_d   = skid_q;
        skid_v_d = 1'b0;
        skid_d   = IDLE;
      end
    end else if (accept) begin
      if (!main_v_q || retire) begin
        main_v_d = 1'b1;
        main_d   = in_data;
      end else begin
        skid_v_d = 1'b1;
        skid_d   = in_data;
      end
    end else if (retire) begin
      main_v_d = 1'b0;
      main_d   = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_v_q   <= 1'b0;
      main_q     <= IDLE;
      skid_v_q   <= 1'b0;
      skid_q     <= IDLE;
      in_ready_q <= 1'b1;
    end else begin
      main_v_q   <= main_v_d;
      main_q     <= main_d;
      skid_v_q   <= skid_v_d;
      skid_q     <= skid_d;
      in_ready_q <= !skid_v_d;
    end
  end
`else
  assign in_ready = !main_v_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Flush beats a same-cycle accept; empty slot always shows the bubble.
  always_comb begin
    main_v_d = main_v_q;
    main_d   = main_q;
    if (flush) begin
      main_v_d = 1'b0;
      main_d   = IDLE;
    end else if (accept) begin
      main_v_d = 1'b1;
      main_d   = in_data;
    end else if (retire) begin
      main_v_d = 1'b0;
      main_d   = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_v_q <= 1'b0;
      main_q   <= IDLE;
    end else begin
      main_v_q <= main_v_d;
      main_q   <= main_d;
    end
  end
`endif

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline stage: holding register plus field slicing and pc+4.
// Define IF_ID_SKID_EN to build the skid-buffered variant.
module if_id_stage
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [XLEN-1:0]     in_pc,
  input  logic [XLEN-1:0]     in_instr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_pc,
  output logic [XLEN-1:0]     out_pc4,
  output logic [XLEN-1:0]     out_instr,
  output logic [OPCODE_W-1:0] out_opcode,
  output logic [REG_W-1:0]    out_rs,
  output logic [REG_W-1:0]    out_rt,
  output logic [REG_W-1:0]    out_rd,
  output logic [SHAMT_W-1:0]  out_shamt,
  output logic [FUNCT_W-1:0]  out_funct,
  output logic [IMM_W-1:0]    out_imm16,
  output logic [TARGET_W-1:0] out_target26
);

  if_id_payload_t in_data;
  if_id_payload_t out_data;

  assign in_data.pc    = in_pc;
  assign in_data.instr = in_instr;

  if_id_skid #(
    .NOP_INSTR (NOP_INSTR)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  assign out_pc    = out_data.pc;
  assign out_instr = out_data.instr;
  assign out_pc4   = out_pc + PC_STEP;

  // Decode fields are plain slices of the held word.
  assign out_opcode   = out_instr[OPCODE_LSB +: OPCODE_W];
  assign out_rs       = out_instr[RS_LSB     +: REG_W];
  assign out_rt       = out_instr[RT_LSB     +: REG_W];
  assign out_rd       = out_instr[RD_LSB     +: REG_W];
  assign out_shamt    = out_instr[SHAMT_LSB  +: SHAMT_W];
  assign out_funct    = out_instr[FUNCT_LSB  +: FUNCT_W];
  assign out_imm16    = out_instr[IMM_LSB    +: IMM_W];
  assign out_target26 = out_instr[TARGET_LSB +: TARGET_W];

endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard bench for if_id_stage; covers both builds (IF_ID_SKID_EN).
module tb_if_id_stage;
  import mips_pkg::*;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic [25:0] target26;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_pc4;
  logic [31:0] out_instr;
  logic [5:0]  out_opcode;
  logic [4:0]  out_rs;
  logic [4:0]  out_rt;
  logic [4:0]  out_rd;
  logic [4:0]  out_shamt;
  logic [5:0]  out_funct;
  logic [15:0] out_imm16;
  logic [25:0] out_target26;

  int   nvec = 0;
  int   nerr = 0;
  vec_t vecs[8];
  vec_t exp_q[$];

  if_id_stage #(.NOP_INSTR(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_pc4(out_pc4),
    .out_instr(out_instr), .out_opcode(out_opcode), .out_rs(out_rs), .out_rt(out_rt),
    .out_rd(out_rd), .out_shamt(out_shamt), .out_funct(out_funct), .out_imm16(out_imm16),
    .out_target26(out_target26)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: on every presented handshake, pop and compare against the head.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (out_ready && !flush) begin
          if (exp_q.size() == 0) begin
            nvec++;
            nerr++;
            $display("FAIL unexpected_word: got pc %h instr %h expected none", out_pc, out_instr);
          end else begin
            vec_t e;
            e = exp_q.pop_front();
            chk("pc", out_pc, e.pc);
            chk("instr", out_instr, e.instr);
            chk("pc4", out_pc4, e.pc4);
            chk("opcode", 32'(out_opcode), 32'(e.opcode));
            chk("rs", 32'(out_rs), 32'(e.rs));
            chk("rt", 32'(out_rt), 32'(e.rt));
            chk("rd", 32'(out_rd), 32'(e.rd));
            chk("shamt", 32'(out_shamt), 32'(e.shamt));
            chk("funct", 32'(out_funct), 32'(e.funct));
            chk("imm16", 32'(out_imm16), 32'(e.imm16));
            chk("target26", 32'(out_target26), 32'(e.target26));
          end
        end
      end else begin
        chk("idle_instr", out_instr, 32'h0);
        chk("idle_pc", out_pc, 32'h0);
      end
    end
  end

  // Present one word and hold it until accepted; push its expectation on accept.
  task automatic send(input int i);
    bit done = 0;
    in_valid = 1'b1;
    in_pc    = vecs[i].pc;
    in_instr = vecs[i].instr;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(vecs[i]);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      nvec++;
      nerr++;
      $display("FAIL send_timeout: got no accept for pc %h expected accept", vecs[i].pc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    //          pc            instr         pc4           op        rs  rt  rd     shamt  funct  imm16     target26
    vecs[0] = '{32'h0000_0100, 32'h2008_FFFF, 32'h0000_0104, OP_ADDI,  0,  8, 5'h1F, 5'h1F, 6'h3F, 16'hFFFF, 26'h008_FFFF};
    vecs[1] = '{32'h0000_0104, 32'h8C02_0004, 32'h0000_0108, OP_LW,    0,  2, 5'h00, 5'h00, 6'h04, 16'h0004, 26'h002_0004};
    vecs[2] = '{32'h0000_0108, 32'h012A_4020, 32'h0000_010C, OP_RTYPE, 9, 10, 5'h08, 5'h00, 6'h20, 16'h4020, 26'h12A_4020};
    vecs[3] = '{32'hFFFF_FFFC, 32'h0800_0040, 32'h0000_0000, OP_J,     0,  0, 5'h00, 5'h01, 6'h00, 16'h0040, 26'h000_0040};
    vecs[4] = '{32'h0000_0200, 32'h8C02_0004, 32'h0000_0204, OP_LW,    0,  2, 5'h00, 5'h00, 6'h04, 16'h0004, 26'h002_0004};
    vecs[5] = '{32'h0000_0300, 32'h3C01_DEAD, 32'h0000_0304, OP_LUI,   0,  1, 5'h1B, 5'h1A, 6'h2D, 16'hDEAD, 26'h001_DEAD};
    vecs[6] = '{32'h0000_0304, 32'hAFBF_0010, 32'h0000_0308, OP_SW,   29, 31, 5'h00, 5'h00, 6'h10, 16'h0010, 26'h3BF_0010};
    vecs[7] = '{32'h0000_0308, 32'h0000_0000, 32'h0000_030C, OP_RTYPE, 0,  0, 5'h00, 5'h00, 6'h00, 16'h0000, 26'h000_0000};

    flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0; out_ready = 1'b0;

    // Reset state
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    idle(2);
    rst = 1'b0;

    // Full-throughput stream, latency 1
    out_ready = 1'b1;
    send(0);
    chk("lat_valid", 32'(out_valid), 32'h1);
    chk("lat_pc", out_pc, 32'h0000_0100);
    chk("lat_pc4", out_pc4, 32'h0000_0104);
    send(1);
    send(2);
    idle(3);
    chk("stream_drained", 32'(exp_q.size()), 32'h0);

    // pc+4 wraps at the top of the address space
    send(3);
    chk("wrap_pc", out_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", out_pc4, 32'h0000_0000);
    idle(2);

    // Backpressure
    out_ready = 1'b0;
`ifdef IF_ID_SKID_EN
    send(5);
    send(6);
    chk("bp_in_ready_full", 32'(in_ready), 32'h0);
    chk("bp_hold_pc", out_pc, 32'h0000_0300);
    idle(1);
    chk("bp_hold_pc2", out_pc, 32'h0000_0300);
    chk("bp_hold_instr2", out_instr, 32'h3C01_DEAD);
    chk("bp_in_ready_full2", 32'(in_ready), 32'h0);
    out_ready = 1'b1;
    send(7);
`else
    send(5);
    chk("bp_in_ready_comb", 32'(in_ready), 32'h0);
    chk("bp_hold_pc", out_pc, 32'h0000_0300);
    idle(1);
    chk("bp_hold_pc2", out_pc, 32'h0000_0300);
    chk("bp_hold_instr2", out_instr, 32'h3C01_DEAD);
    chk("bp_in_ready_comb2", 32'(in_ready), 32'h0);
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_release", 32'(in_ready), 32'h1);
    send(6);
    send(7);
`endif
    idle(3);
    chk("bp_drained", 32'(exp_q.size()), 32'h0);

    // Flush races an accept: the word must never appear
    in_valid = 1'b1; in_pc = vecs[4].pc; in_instr = vecs[4].instr; flush = 1'b1;
    @(negedge clk);
    chk("race_in_ready", 32'(in_ready), 32'h1);
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("race_out_valid", 32'(out_valid), 32'h0);
    chk("race_out_instr", out_instr, 32'h0);
    chk("race_in_ready_after", 32'(in_ready), 32'h1);
    idle(3);

    // Flush discards a held word
    out_ready = 1'b0;
    send(0);
    chk("fl_held_valid", 32'(out_valid), 32'h1);
    flush = 1'b1;
    idle(1);
    flush = 1'b0;
    exp_q.delete();
    chk("fl_out_valid", 32'(out_valid), 32'h0);
    chk("fl_out_pc", out_pc, 32'h0);
    chk("fl_in_ready", 32'(in_ready), 32'h1);

    // Asynchronous reset mid-stream, then accept on the first edge after release
    send(1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'h0);
    chk("arst_out_pc", out_pc, 32'h0);
    chk("arst_out_instr", out_instr, 32'h0);
    chk("arst_in_ready", 32'(in_ready), 32'h1);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    send(2);
    chk("post_rst_valid", 32'(out_valid), 32'h1);
    chk("post_rst_pc", out_pc, 32'h0000_0108);
    idle(3);
    chk("final_drained", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 SHALL have parameter NOP_INSTR, default 32'h0000_0000, instruction word presented on out_instr while out_valid=0.
REQ-002 SHALL have port clk, input, 1 bit, single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-004 SHALL have port flush, input, 1 bit, discards all held instructions.
REQ-005 SHALL have ports in_valid (input, 1), in_ready (output, 1), in_pc (input, 32), in_instr (input, 32): fetch-side handshake and payload.
REQ-006 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_pc (output, 32), out_pc4 (output, 32), out_instr (output, 32): decode-side handshake and payload.
REQ-007 SHALL have field outputs out_opcode (6), out_rs (5), out_rt (5), out_rd (5), out_shamt (5), out_funct (6), out_imm16 (16, feeds the 16-to-32 sign extender), out_target26 (26).

Function
REQ-008 SHALL accept a word when in_valid=1 and in_ready=1 at a rising edge; SHALL present it with out_valid=1 from the next cycle (latency 1).
REQ-009 SHALL retire the output word when out_valid=1 and out_ready=1 at a rising edge.
REQ-010 SHALL hold out_pc/out_instr and all fields stable while out_valid=1 and out_ready=0.
REQ-011 SHALL slice fields combinationally from out_instr: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0], imm16[15:0], target26[25:0].
REQ-012 SHALL drive out_pc4 = out_pc + 4 modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-013 SHALL drive out_instr = NOP_INSTR and out_pc = 0 whenever out_valid=0.
REQ-014 SHALL preserve order; no word dropped or duplicated except by flush.
REQ-015 SHALL, on flush=1 at a rising edge, clear all valid bits, set in_ready=1 next cycle; a word handshaking in that same cycle is dropped (flush wins).
REQ-016 SHALL allow simultaneous accept and retire in one cycle at full throughput (one word/cycle sustained with out_ready=1).

Reset
REQ-017 SHALL on rst=1 asynchronously force out_valid=0, out_pc=0, out_instr=NOP_INSTR, skid slot empty, in_ready=1 (skid build) or combinational rule (non-skid build).
REQ-018 SHALL drop any in-flight word when rst asserts mid-transfer; first accept permitted on the first edge after rst deasserts.

Configuration
REQ-019 SHALL compile a 1-entry skid slot when macro IF_ID_SKID_EN is defined: in_ready is a register output = skid slot empty; a word accepted while main slot full and out_ready=0 enters the skid slot and moves to main on the next retire.
REQ-020 SHALL, without IF_ID_SKID_EN, have no skid slot and drive in_ready = !out_valid || out_ready combinationally.
REQ-021 SHALL exhibit identical in/out word sequences in both builds for the same handshake traces where both accept.

Structure
REQ-022 SHALL take field widths, bit positions, NOP_INSTR default and opcode constants (e.g. OP_RTYPE 6'h00, OP_ADDI 6'h08, OP_LW 6'h23, OP_J 6'h02) from shared package mips_pkg.
REQ-023 SHALL implement the valid/ready storage as one sub-module if_id_skid (payload 64 bits: pc+instr); field slicing and pc4 adder stay in if_id_stage.

Verification
REQ-024 Reset: rst=1 mid-stream -> out_valid=0, out_instr=32'h0, out_pc=0, in_ready=1 immediately, no clk needed.
REQ-025 Throughput: pc 0x100/0x104/0x108 streamed, out_ready=1 -> each appears one cycle later; instr 0x2008FFFF gives opcode 0x08, rs 0, rt 8, imm16 0xFFFF, out_pc4 0x104 for pc 0x100.
REQ-026 Backpressure (skid build): out_ready=0 for 3 cycles with in_valid=1 -> two words held, in_ready=0 from 2nd cycle; release -> both emitted in order, none lost.
REQ-027 Flush race: flush=1 same edge as in_valid&in_ready with instr 0x8C020004 -> next cycle out_valid=0, word never emitted.
REQ-028 Wrap: in_pc 0xFFFFFFFC -> out_pc4 0x00000000.
REQ-029 Non-skid build: out_valid=1, out_ready=0 -> in_ready=0 same cycle; out_ready=1 -> in_ready=1 same cycle.
